m_sw_debounce: RTL and testbench

//  Input-conditioning stage for the board push-buttons/slide switches that drive the
//  a/b operands of the gate-level exercise modules (e.g. the 2-input OR stage).

---
 rtl/m_sw_debounce.sv | 79 +++++++
 tb/tb_m_sw_debounce.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/m_sw_debounce.sv
// Switch input conditioner: 2-FF synchroniser plus per-channel stability-counter debounce,
// producing a clean level and registered 1-cycle rise/fall pulses for each channel.
//
// Per-channel state (implicit, derived from s2_q vs out_q):
//   state    | meaning
//   IDLE     | synchronised input matches sw_out, counter parked at 0
//   CHANGING | synchronised input differs, counter advances toward acceptance
module m_sw_debounce #(
    parameter int N_CH          = 2,
    parameter int STABLE_CYCLES = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] sw_in,
    output logic [N_CH-1:0] sw_out,
    output logic [N_CH-1:0] sw_rise,
    output logic [N_CH-1:0] sw_fall,
    output logic            any_edge
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [N_CH-1:0]            s1_q;
    logic [N_CH-1:0]            s2_q;
    logic [N_CH-1:0]            out_q;
    logic [N_CH-1:0]            out_d;
    logic [N_CH-1:0]            rise_q;
    logic [N_CH-1:0]            rise_d;
    logic [N_CH-1:0]            fall_q;
    logic [N_CH-1:0]            fall_d;
    logic [N_CH-1:0][CNT_W-1:0] cnt_q;
    logic [N_CH-1:0][CNT_W-1:0] cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= '0;
            s2_q   <= '0;
            out_q  <= '0;
            rise_q <= '0;
            fall_q <= '0;
            cnt_q  <= '0;
        end else begin
            s1_q   <= sw_in;
            s2_q   <= s1_q;
            out_q  <= out_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            cnt_q  <= cnt_d;
        end
    end

    // A returning level (s2 == sw_out) discards any partial count: the run must be unbroken.
    always_comb begin
        cnt_d  = '0;
        out_d  = out_q;
        rise_d = '0;
        fall_d = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (s2_q[i] != out_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    out_d[i]  = s2_q[i];
                    rise_d[i] = s2_q[i];
                    fall_d[i] = ~s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        sw_out   = out_q;
        sw_rise  = rise_q;
        sw_fall  = fall_q;
        any_edge = |(rise_q | fall_q);
    end

endmodule

// File: tb/tb_m_sw_debounce.sv
// Bench for m_sw_debounce: directed scenarios plus random switch activity, checked every cycle
// against a history-window model ("last S synchronised samples all differ from the output").
module tb_m_sw_debounce;

    localparam int N_CH = 2;
    localparam int S    = 4;
    localparam int HMAX = 4096;

    logic            clk;
    logic            rst_n;
    logic [N_CH-1:0] sw_in;
    logic [N_CH-1:0] sw_out;
    logic [N_CH-1:0] sw_rise;
    logic [N_CH-1:0] sw_fall;
    logic            any_edge;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [N_CH-1:0] md1, md2;
    logic [N_CH-1:0] m_out, m_rise, m_fall;
    logic [N_CH-1:0] hist [0:HMAX-1];
    int              e;
    int              clear_at [N_CH];

    m_sw_debounce #(.N_CH(N_CH), .STABLE_CYCLES(S)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sw_in    (sw_in),
        .sw_out   (sw_out),
        .sw_rise  (sw_rise),
        .sw_fall  (sw_fall),
        .any_edge (any_edge)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        md1    = '0;
        md2    = '0;
        m_out  = '0;
        m_rise = '0;
        m_fall = '0;
        for (int c = 0; c < N_CH; c++) clear_at[c] = e;
    endtask

    task automatic model_edge();
        logic [N_CH-1:0] s2v;
        bit              ok;
        s2v = md2;
        md2 = md1;
        md1 = sw_in;
        e++;
        hist[e % HMAX] = s2v;
        m_rise = '0;
        m_fall = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (e - clear_at[c] >= S) begin
                ok = 1'b1;
                for (int j = 0; j < S; j++)
                    if (hist[(e - j) % HMAX][c] == m_out[c]) ok = 1'b0;
                if (ok) begin
                    m_out[c]    = s2v[c];
                    m_rise[c]   = s2v[c];
                    m_fall[c]   = ~s2v[c];
                    clear_at[c] = e;
                end
            end
        end
    endtask

    task automatic check_outputs(input string ctx);
        chk({ctx, ":sw_out"},   32'(sw_out),   32'(m_out));
        chk({ctx, ":sw_rise"},  32'(sw_rise),  32'(m_rise));
        chk({ctx, ":sw_fall"},  32'(sw_fall),  32'(m_fall));
        chk({ctx, ":any_edge"}, 32'(any_edge), 32'(|(m_rise | m_fall)));
    endtask

    task automatic tick(input string ctx);
        @(posedge clk);
        if (rst_n) model_edge();
        else       model_reset();
        @(negedge clk);
        check_outputs(ctx);
    endtask

    task automatic tick_n(input string ctx, input int n);
        for (int k = 0; k < n; k++) tick(ctx);
    endtask

    int rises, falls, anys, first_k;

    initial begin
        e     = 0;
        rst_n = 1'b1;
        sw_in = '0;
        model_reset();

        // 1: async reset without a clock edge, then held with inputs high
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_outputs("t1_async");
        sw_in = 2'b11;
        tick_n("t1_rst", 3);

        // 2: single clean rise on channel 0
        rst_n = 1'b1;
        sw_in = 2'b00;
        tick_n("t2_idle", 3);
        sw_in = 2'b01;
        rises = 0; falls = 0; anys = 0;
        for (int k = 1; k <= 8; k++) begin
            tick("t2");
            chk("t2_level", 32'(sw_out[0]), 32'(k >= 6));
            if (sw_rise[0]) rises++;
            if (sw_fall != 0) falls++;
            if (any_edge) anys++;
        end
        chk("t2_rise_count", 32'(rises), 32'd1);
        chk("t2_fall_count", 32'(falls), 32'd0);
        chk("t2_any_count",  32'(anys),  32'd1);

        // 3: bounce 1,0,1,0,1 then hold
        sw_in = 2'b00;
        tick_n("t3_settle", 10);
        sw_in[0] = 1'b1; tick("t3_b");
        sw_in[0] = 1'b0; tick("t3_b");
        sw_in[0] = 1'b1; tick("t3_b");
        sw_in[0] = 1'b0; tick("t3_b");
        sw_in[0] = 1'b1;
        rises = 0; first_k = -1;
        for (int k = 1; k <= 12; k++) begin
            tick("t3_hold");
            if (sw_rise[0]) begin
                rises++;
                if (first_k < 0) first_k = k;
            end
        end
        chk("t3_rise_count", 32'(rises),   32'd1);
        chk("t3_rise_edge",  32'(first_k), 32'd6);

        // 4: short pulse on channel 1 is rejected
        sw_in[1] = 1'b1;
        tick_n("t4_pulse", 3);
        sw_in[1] = 1'b0;
        anys = 0;
        for (int k = 0; k < 10; k++) begin
            tick("t4_after");
            if (sw_rise[1] || sw_fall[1] || sw_out[1]) anys++;
        end
        chk("t4_ch1_activity", 32'(anys), 32'd0);

        // 5: both channels switch together
        sw_in = 2'b00;
        tick_n("t5_settle", 10);
        sw_in = 2'b11;
        anys = 0; rises = 0;
        for (int k = 0; k < 10; k++) begin
            tick("t5_up");
            if (any_edge) anys++;
            if (sw_rise == 2'b11) rises++;
        end
        chk("t5_up_any",   32'(anys),  32'd1);
        chk("t5_up_rise",  32'(rises), 32'd1);
        sw_in = 2'b00;
        anys = 0; falls = 0;
        for (int k = 0; k < 10; k++) begin
            tick("t5_dn");
            if (any_edge) anys++;
            if (sw_fall == 2'b11) falls++;
        end
        chk("t5_dn_any",  32'(anys),  32'd1);
        chk("t5_dn_fall", 32'(falls), 32'd1);

        // 6: reset mid-count, level held through reset
        sw_in = 2'b01;
        tick_n("t6_count", 4);
        rst_n = 1'b0;
        model_reset();
        #1 check_outputs("t6_async");
        chk("t6_out_in_reset", 32'(sw_out[0]), 32'd0);
        tick_n("t6_rst", 2);
        rst_n = 1'b1;
        rises = 0;
        for (int k = 1; k <= 8; k++) begin
            tick("t6_rel");
            chk("t6_level", 32'(sw_out[0]), 32'(k >= 6));
            if (sw_rise[0]) rises++;
        end
        chk("t6_rise_count", 32'(rises), 32'd1);

        // random activity: alternating noisy and calm phases, occasional resets
        for (int ph = 0; ph < 30; ph++) begin
            for (int k = 0; k < 50; k++) begin
                for (int c = 0; c < N_CH; c++) begin
                    if ((ph % 2 == 0) ? ($urandom_range(5) == 0) : ($urandom_range(39) == 0))
                        sw_in[c] = ~sw_in[c];
                end
                if (rst_n && $urandom_range(299) == 0) begin
                    rst_n = 1'b0;
                    model_reset();
                end else if (!rst_n && $urandom_range(1) == 0) begin
                    rst_n = 1'b1;
                end
                tick("rand");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
